// File: rtl/mem_stage.sv
// MEM pipeline stage: decodes the EX memory op into a bus_if word request, checks
// word alignment, merges load data and registers the MEM/WB pipeline fields.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_en,
    input  logic [29:0] ex_pc,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [31:0] ex_out,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    input  logic [1:0]  ex_ctrl_op,
    input  logic        ex_br_flag,
    input  logic [2:0]  ex_exp_code,
    output logic [29:0] addr,
    output logic        as_,
    output logic        rw,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    output logic [31:0] fwd_data,
    output logic        mem_en,
    output logic [29:0] mem_pc,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [1:0]  mem_ctrl_op,
    output logic        mem_br_flag,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 30;

    localparam logic [1:0] OP_LDW         = 2'd1;
    localparam logic [1:0] OP_STW         = 2'd2;
    localparam logic [2:0] EXP_NONE       = 3'd0;
    localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;

    logic w_is_ldw;
    logic w_is_stw;
    logic w_is_mem;
    logic w_miss_align;
    logic w_has_exp;

    // Request decode; an incoming exception suppresses the strobe but not the check
    always_comb begin
        w_is_ldw     = (ex_mem_op == OP_LDW);
        w_is_stw     = (ex_mem_op == OP_STW);
        w_is_mem     = w_is_ldw | w_is_stw;
        w_has_exp    = (ex_exp_code != EXP_NONE);
        w_miss_align = ex_en & w_is_mem & (ex_out[1:0] != 2'b00);
        as_          = ~(ex_en & w_is_mem & ~w_miss_align & ~w_has_exp);
        rw           = w_is_stw;
        addr         = ADDR_W'(ex_out[DATA_W-1:2]);
        wr_data      = ex_mem_wr_data;
        fwd_data     = w_is_ldw ? rd_data : ex_out;
    end

    // MEM/WB register: reset > stall > flush > misalignment > normal load
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en       <= 1'b0;
            mem_pc       <= '0;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= 1'b1;
            mem_ctrl_op  <= '0;
            mem_br_flag  <= 1'b0;
            mem_exp_code <= EXP_NONE;
            mem_out      <= '0;
        end else if (!stall) begin
            if (flush) begin
                mem_en       <= 1'b0;
                mem_pc       <= '0;
                mem_dst_addr <= '0;
                mem_gpr_we_  <= 1'b1;
                mem_ctrl_op  <= '0;
                mem_br_flag  <= 1'b0;
                mem_exp_code <= EXP_NONE;
                mem_out      <= '0;
            end else if (w_miss_align && !w_has_exp) begin
                mem_en       <= 1'b1;
                mem_pc       <= ex_pc;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= 1'b1;
                mem_ctrl_op  <= ex_ctrl_op;
                mem_br_flag  <= ex_br_flag;
                mem_exp_code <= EXP_MISS_ALIGN;
                mem_out      <= '0;
            end else begin
                mem_en       <= ex_en;
                mem_pc       <= ex_pc;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= ex_gpr_we_ | w_is_stw;
                mem_ctrl_op  <= ex_ctrl_op;
                mem_br_flag  <= ex_br_flag;
                mem_exp_code <= ex_exp_code;
                mem_out      <= fwd_data;
            end
        end
    end

endmodule
